// File: rtl/core_mem_serv_pkg.sv
// Shared GPU definitions for the core memory server: FSM encoding, core count
// and default bus widths.
package core_mem_serv_pkg;

    localparam int CORE_CNT_W = 4;
    localparam int N_CORES    = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } serv_state_e;

    function automatic logic [N_CORES-1:0] core_onehot(input logic [CORE_CNT_W-1:0] idx);
        core_onehot      = '0;
        core_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/core_mem_serv_if.sv
// Single-beat shared memory port: request handshake plus response strobe.
interface core_mem_serv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/core_mem_serv_core_req_mux.sv
// Combinational 16:1 select of a core's write enable, address and write data.
// Shared with the instruction-fetch server.
module core_req_mux
    import core_mem_serv_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [CORE_CNT_W-1:0]     sel,
    input  logic [N_CORES-1:0]        we,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] wdata,
    output logic                      sel_we,
    output logic [ADDR_W-1:0]         sel_addr,
    output logic [DATA_W-1:0]         sel_wdata
);
    assign sel_we    = we[sel];
    assign sel_addr  = addr[sel*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[sel*DATA_W +: DATA_W];
endmodule

// File: rtl/core_mem_serv.sv
// Serves the core picked by the round-robin pointer with one memory transaction,
// holding the arbiter via core_serv. Define SERV_TIMEOUT_EN for timeout + core_err.
module core_mem_serv
    import core_mem_serv_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef SERV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_req,
    input  logic [N_CORES-1:0]        core_we,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]         core_rdata,
    input  logic [CORE_CNT_W-1:0]     core_cnt,
    output logic                      core_serv,
    output logic [N_CORES-1:0]        core_val,
`ifdef SERV_TIMEOUT_EN
    output logic                      core_err,
`endif
    core_mem_serv_if.master           mem
);
    serv_state_e           state, state_nxt;
    logic [CORE_CNT_W-1:0] sel;
    logic                  valid_q, we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  mux_we;
    logic [ADDR_W-1:0]     mux_addr;
    logic [DATA_W-1:0]     mux_wdata;
    logic                  grant, accept, resp, timeout;

    core_req_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .sel       (core_cnt),
        .we        (core_we),
        .addr      (core_addr),
        .wdata     (core_wdata),
        .sel_we    (mux_we),
        .sel_addr  (mux_addr),
        .sel_wdata (mux_wdata)
    );

    assign grant  = (state == IDLE) && core_req[core_cnt];
    assign accept = (state == ISSUE) && valid_q && mem.mem_ready;
    // A response only counts if it lands with acceptance or while waiting for it.
    assign resp   = mem.mem_rvalid && (accept || (state == WAIT));

    assign core_val       = core_req;
    assign mem.mem_valid  = valid_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;

`ifdef SERV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = ((state == ISSUE) || (state == WAIT)) &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset)                                to_cnt <= '0;
        else if (grant)                           to_cnt <= '0;
        else if ((state == ISSUE) || (state == WAIT)) to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) core_err <= 1'b0;
        else       core_err <= (state_nxt == DONE) && !resp;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        core_serv = 1'b0;
        case (state)
            IDLE: begin
                core_serv = core_req[core_cnt];
                if (core_req[core_cnt]) state_nxt = ISSUE;
            end
            ISSUE: begin
                core_serv = 1'b1;
                if (resp || timeout) state_nxt = DONE;
                else if (accept)     state_nxt = WAIT;
            end
            WAIT: begin
                core_serv = 1'b1;
                if (resp || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_ack   <= '0;
            core_rdata <= '0;
        end else begin
            state      <= state_nxt;
            core_ack   <= '0;
            core_rdata <= '0;
            if (grant) begin
                sel     <= core_cnt;
                valid_q <= 1'b1;
                we_q    <= mux_we;
                addr_q  <= mux_addr;
                wdata_q <= mux_wdata;
            end else if ((state == ISSUE) && (state_nxt != ISSUE)) begin
                valid_q <= 1'b0;
            end
            // DONE is only reachable from ISSUE/WAIT, so this fires once per transaction.
            if (state_nxt == DONE) begin
                core_ack <= core_onehot(sel);
                if (resp && !we_q) core_rdata <= mem.mem_rdata;
            end
        end
    end

    // The arbiter must hold its pointer while a transaction is in flight.
    sel_hold_a: assert property (@(posedge clock) disable iff (reset)
        ((state == ISSUE) || (state == WAIT)) |-> (core_cnt == sel));

endmodule

// File: tb/tb_core_mem_serv.sv
// Directed + randomized bench for core_mem_serv with a transaction-level model
// of cores, arbiter pointer and memory responder.
module tb_core_mem_serv;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [15:0]      core_req, core_we, core_ack, core_val;
    logic [16*AW-1:0] core_addr;
    logic [16*DW-1:0] core_wdata;
    logic [DW-1:0]    core_rdata;
    logic [3:0]       core_cnt;
    logic             core_serv;
`ifdef SERV_TIMEOUT_EN
    logic             core_err;
`endif

    core_mem_serv_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    core_mem_serv #(
        .ADDR_W(AW), .DATA_W(DW)
`ifdef SERV_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .core_cnt   (core_cnt),
        .core_serv  (core_serv),
        .core_val   (core_val),
`ifdef SERV_TIMEOUT_EN
        .core_err   (core_err),
`endif
        .mem        (mem)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            failures = 0;
    bit            arb_en = 0;
    int            n_done = 0;
    bit            exp_ack = 0;
    int            exp_core = 0;
    logic [DW-1:0] exp_rdata = '0;
    bit            outstanding = 0;
    int            cur_core = 0;
    logic          cur_we = 1'b0;
    int            wcnt = 0;
    int            acc_q[$];
    int            ack_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we[i]              = w;
        core_addr[i*AW +: AW]   = a;
        core_wdata[i*DW +: DW]  = d;
        core_req[i]             = 1'b1;
    endtask

    // One cycle of cores + arbiter + memory, checked against the transaction model.
    task automatic cycle_step(input bit gen);
        int          just;
        int          c;
        logic        serv_prev;
        logic [15:0] oh;
        just = -1;
        if (exp_ack) begin
            oh = 16'h1 << exp_core;
            chk("ack_core", core_ack, oh);
            chk("ack_rdata", core_rdata, exp_rdata);
`ifdef SERV_TIMEOUT_EN
            chk("ack_err", core_err, 0);
`endif
            ack_q.push_back(exp_core);
            core_req[exp_core] = 1'b0;
            just = exp_core;
            n_done++;
            exp_ack = 0;
        end else begin
            chk("idle_ack", core_ack, 0);
        end
        if (gen)
            for (int i = 0; i < 16; i++)
                if (!core_req[i] && i != just && $urandom_range(7) == 0)
                    set_req(i, 1'($urandom_range(1)), {4'(i), 28'($urandom)}, $urandom);
        if (mem.mem_valid || outstanding) wcnt++;
        else                              wcnt = 0;
        mem.mem_ready  = ($urandom_range(2) != 0) || (wcnt >= 4);
        mem.mem_rvalid = ($urandom_range(1) != 0) || (wcnt >= 4);
        mem.mem_rdata  = $urandom;
        #1;
        chk("core_val", core_val, core_req);
        if (mem.mem_valid && mem.mem_ready) begin
            c = int'(mem.mem_addr[AW-1 -: 4]);
            chk("acc_req", core_req[c], 1);
            chk("acc_we", mem.mem_we, core_we[c]);
            chk("acc_addr", mem.mem_addr, core_addr[c*AW +: AW]);
            chk("acc_wdata", mem.mem_wdata, core_wdata[c*DW +: DW]);
            acc_q.push_back(c);
            cur_core    = c;
            cur_we      = mem.mem_we;
            outstanding = 1;
        end
        if (mem.mem_rvalid && outstanding) begin
            exp_ack     = 1;
            exp_core    = cur_core;
            exp_rdata   = cur_we ? '0 : mem.mem_rdata;
            outstanding = 0;
        end
        serv_prev = core_serv;
        tick();
        if (arb_en && !serv_prev) core_cnt = core_cnt + 4'd1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int lat;
        int guard;

        reset = 1'b1;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0; core_cnt = '0;
        mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        tick(); tick();
        chk("rst_valid", mem.mem_valid, 0);
        chk("rst_we", mem.mem_we, 0);
        chk("rst_addr", mem.mem_addr, 0);
        chk("rst_wdata", mem.mem_wdata, 0);
        chk("rst_ack", core_ack, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_serv", core_serv, 0);
        reset = 1'b0;
        tick();

        // Single read from core 3.
        core_cnt = 4'd3; mem.mem_ready = 1'b1;
        set_req(3, 1'b0, 32'h40, 32'h0);
        #1;
        chk("rd_serv_idle", core_serv, 1);
        chk("rd_val", core_val, 16'h0008);
        tick();
        chk("rd_issue_valid", mem.mem_valid, 1);
        chk("rd_addr", mem.mem_addr, 32'h40);
        chk("rd_we", mem.mem_we, 0);
        chk("rd_serv_issue", core_serv, 1);
        tick();
        chk("rd_wait_valid", mem.mem_valid, 0);
        chk("rd_serv_wait", core_serv, 1);
        chk("rd_wait_ack", core_ack, 0);
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEADBEEF;
        tick();
        mem.mem_rvalid = 1'b0;
        chk("rd_ack", core_ack, 16'h0008);
        chk("rd_rdata", core_rdata, 32'hDEADBEEF);
        chk("rd_serv_done", core_serv, 0);
        core_req[3] = 1'b0; mem.mem_ready = 1'b0;
        tick();
        chk("rd_ack_clear", core_ack, 0);
        chk("rd_rdata_clear", core_rdata, 0);

        // Write from core 5 under 5 cycles of backpressure.
        core_cnt = 4'd5;
        set_req(5, 1'b1, 32'h100, 32'hA5A5_0005);
        tick();
        n_acc = 0;
        repeat (5) begin
            chk("bp_valid", mem.mem_valid, 1);
            chk("bp_addr", mem.mem_addr, 32'h100);
            chk("bp_wdata", mem.mem_wdata, 32'hA5A5_0005);
            chk("bp_we", mem.mem_we, 1);
            chk("bp_serv", core_serv, 1);
            if (mem.mem_valid && mem.mem_ready) n_acc++;
            tick();
        end
        mem.mem_ready = 1'b1;
        #1;
        if (mem.mem_valid && mem.mem_ready) n_acc++;
        tick();
        mem.mem_ready = 1'b0;
        chk("bp_drop", mem.mem_valid, 0);
        chk("bp_accepts", n_acc, 1);
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h1234;
        tick();
        mem.mem_rvalid = 1'b0;
        chk("bp_ack", core_ack, 16'h0020);
        chk("bp_wr_rdata", core_rdata, 0);
        core_req[5] = 1'b0;
        tick();

        // Accept and response in the same cycle.
        core_cnt = 4'd7; mem.mem_ready = 1'b1; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
        set_req(7, 1'b0, 32'h77C, 32'h0);
        lat = 0;
        while (core_ack == 16'h0 && lat < 10) begin tick(); lat++; end
        chk("co_latency_cycles", lat + 1, 3);
        chk("co_ack", core_ack, 16'h0080);
        chk("co_rdata", core_rdata, 32'hCAFEF00D);
        mem.mem_rvalid = 1'b0; mem.mem_ready = 1'b0; core_req[7] = 1'b0;
        tick();

        // Reset while waiting for a response; a late response must be ignored.
        core_cnt = 4'd2; mem.mem_ready = 1'b1;
        set_req(2, 1'b0, 32'h200, 32'h0);
        tick(); tick();
        mem.mem_ready = 1'b0;
        chk("rw_in_wait_valid", mem.mem_valid, 0);
        chk("rw_in_wait_serv", core_serv, 1);
        reset = 1'b1; core_req[2] = 1'b0;
        tick();
        chk("rw_valid", mem.mem_valid, 0);
        chk("rw_ack", core_ack, 0);
        chk("rw_serv", core_serv, 0);
        reset = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h5555;
        repeat (4) begin
            tick();
            chk("rw_late_ack", core_ack, 0);
            chk("rw_late_valid", mem.mem_valid, 0);
        end
        mem.mem_rvalid = 1'b0;
        tick();

`ifdef SERV_TIMEOUT_EN
        // No response: timeout after 8 ISSUE/WAIT cycles, then a normal request.
        core_cnt = 4'd1; mem.mem_ready = 1'b1;
        set_req(1, 1'b0, 32'h10, 32'h0);
        tick();
        lat = 0;
        while (core_ack == 16'h0 && lat < 20) begin tick(); lat++; end
        chk("to_cycles", lat, 8);
        chk("to_ack", core_ack, 16'h0002);
        chk("to_err", core_err, 1);
        chk("to_rdata", core_rdata, 0);
        core_req[1] = 1'b0; mem.mem_ready = 1'b0;
        tick();
        chk("to_err_clear", core_err, 0);
        set_req(1, 1'b0, 32'h14, 32'h0);
        mem.mem_ready = 1'b1; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h600D;
        lat = 0;
        while (core_ack == 16'h0 && lat < 10) begin tick(); lat++; end
        chk("to_next_ack", core_ack, 16'h0002);
        chk("to_next_err", core_err, 0);
        chk("to_next_rdata", core_rdata, 32'h600D);
        core_req[1] = 1'b0; mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0;
        tick();
`endif

        // All 16 cores write at once; pointer steps whenever core_serv is low.
        core_cnt = 4'd0; arb_en = 1;
        for (int i = 0; i < 16; i++) set_req(i, 1'b1, {4'(i), 28'(i * 16)}, DW'(i));
        acc_q.delete(); ack_q.delete(); n_done = 0;
        guard = 0;
        while (n_done < 16 && guard < 400) begin cycle_step(0); guard++; end
        chk("all16_done", n_done, 16);
        for (int i = 0; i < 16; i++) begin
            if (i < acc_q.size()) chk("all16_mem_order", acc_q[i], i);
            else                  chk("all16_mem_missing", acc_q.size(), 16);
            if (i < ack_q.size()) chk("all16_ack_order", ack_q[i], i);
            else                  chk("all16_ack_missing", ack_q.size(), 16);
        end

        // Random traffic from all cores with random memory timing.
        acc_q.delete(); ack_q.delete(); n_done = 0;
        repeat (1500) cycle_step(1);
        guard = 0;
        while ((core_req != 16'h0 || exp_ack || outstanding) && guard < 600) begin
            cycle_step(0);
            guard++;
        end
        chk("rand_drained", guard < 600, 1);
        chk("rand_acc_vs_ack", acc_q.size(), ack_q.size());
        chk("rand_progress", n_done >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
